// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, operand class enum and special-value builders for the FP add/sub path
package fp_pkg;
  localparam int EXP_W_DEF = 8;
  localparam int FRAC_W_DEF = 23;
  localparam int MAX_W = 64;
  typedef enum logic [2:0] {ZERO, FINITE, INF, QNAN, SNAN} fpClass_e;
  // Builders return MAX_W bits; callers cast down to their format width.
  function automatic logic [MAX_W-1:0] infVal(input logic s, input int expW, input int fracW);
    logic [MAX_W-1:0] ones;
    ones = (MAX_W'(1) << expW) - MAX_W'(1);
    return (MAX_W'(s) << (expW + fracW)) | (ones << fracW);
  endfunction
  function automatic logic [MAX_W-1:0] qnanVal(input int expW, input int fracW);
    return infVal(1'b0, expW, fracW) | (MAX_W'(1) << (fracW - 1));
  endfunction
endpackage

// File: rtl/fp_classify.sv
// fp_classify: combinational class of one operand from its exponent and fraction fields
module fp_classify import fp_pkg::*; #(
  parameter int EXP_W = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
)(
  input  logic [EXP_W-1:0]  expF,
  input  logic [FRAC_W-1:0] fracF,
  output fpClass_e          cls
);
  assign cls = &expF ? (fracF == '0 ? INF : fracF[FRAC_W-1] ? QNAN : SNAN)
             : (expF == '0 && fracF == '0) ? ZERO : FINITE;
endmodule

// File: rtl/fp_addsub_special.sv
// fp_addsub_special: two-stage special-operand resolver in front of the FP adder core
module fp_addsub_special import fp_pkg::*; #(
  parameter int EXP_W = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int CNT_W = 16,
  localparam int W = 1 + EXP_W + FRAC_W
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     inA,
  input  logic [W-1:0]     inB,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_special,
  output logic [W-1:0]     out_result,
  output logic             out_nan,
  input  logic             flag_clr,
  output logic             flag_invalid,
  output logic [CNT_W-1:0] nan_count
);
  localparam logic [W-1:0] QNAN_V = W'(qnanVal(EXP_W, FRAC_W));
  localparam logic [W-1:0] INF_V = W'(infVal(1'b0, EXP_W, FRAC_W));
  fpClass_e clsAIn, clsBIn, clsA, clsB;
  logic s1Valid, sA, sBe, s2Free, hs, anyNan, anySnan, invInf, zA, zB, nanNext, specNext, isNanOut;
  logic [W-2:0] magA, magB;
  logic [W-1:0] resNext;
  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) uClsA (.expF(inA[W-2:FRAC_W]), .fracF(inA[FRAC_W-1:0]), .cls(clsAIn));
  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) uClsB (.expF(inB[W-2:FRAC_W]), .fracF(inB[FRAC_W-1:0]), .cls(clsBIn));
  assign s2Free = !out_valid | out_ready;
  assign in_ready = !s1Valid | s2Free;
  always_ff @(posedge clk) begin
    if (rst) s1Valid <= 1'b0;
    else if (in_ready) s1Valid <= in_valid;
    if (in_ready & in_valid) begin
      clsA <= clsAIn;
      clsB <= clsBIn;
      sA <= inA[W-1];
      sBe <= inB[W-1] ^ op;
      magA <= inA[W-2:0];
      magB <= inB[W-2:0];
    end
  end
  assign anyNan = clsA inside {QNAN, SNAN} || clsB inside {QNAN, SNAN};
  assign anySnan = clsA == SNAN || clsB == SNAN;
  assign invInf = clsA == INF && clsB == INF && sA != sBe;
  assign zA = clsA == ZERO;
  assign zB = clsB == ZERO;
  assign resNext = (anyNan | invInf) ? QNAN_V
                 : clsA == INF ? {sA, INF_V[W-2:0]}
                 : clsB == INF ? {sBe, INF_V[W-2:0]}
                 : (zA & zB) ? {sA & sBe, {(W-1){1'b0}}}
                 : zA ? {sBe, magB}
                 : zB ? {sA, magA} : '0;
  assign specNext = !(clsA == FINITE && clsB == FINITE);
  assign nanNext = anyNan ? anySnan : invInf;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_special <= 1'b0;
      out_result <= '0;
      out_nan <= 1'b0;
    end else if (s2Free & s1Valid) begin
      out_valid <= 1'b1;
      out_special <= specNext;
      out_result <= resNext;
      out_nan <= nanNext;
    end else if (s2Free) out_valid <= 1'b0;
  end
  // Set/increment beats a coincident clear so a delivered NaN is never lost.
  assign hs = out_valid & out_ready;
  assign isNanOut = &out_result[W-2:FRAC_W] & |out_result[FRAC_W-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_invalid <= 1'b0;
      nan_count <= '0;
    end else begin
      flag_invalid <= (hs & out_nan) ? 1'b1 : flag_clr ? 1'b0 : flag_invalid;
      nan_count <= (hs & isNanOut) ? (flag_clr ? CNT_W'(1) : nan_count + CNT_W'(!(&nan_count)))
                 : flag_clr ? '0 : nan_count;
    end
  end
endmodule
